// File: rtl/fc8_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fc8_vram_arbiter
//  Purpose  : Arbitrates the single CPU-side read/write port of the FC8 64KB
//             dual-port VRAM between the CPU bus (requester 0) and the VRAM
//             DMA/fill engine (requester 1). One access is in flight at a
//             time: IDLE -> CMD -> RESP -> DONE, so there is one access every
//             4 cycles. All outputs are registered.
//  Config   : FC8_VRAM_ARB_RR_EN defined   -> round-robin on a tie.
//             FC8_VRAM_ARB_RR_EN undefined -> fixed priority, CPU wins a tie.
//  Ports    : clk, rst_n (async, active low)
//             cpu_req/we/addr/wdata_in, cpu_ack_out, cpu_rdata_out
//             dma_req/we/addr/wdata_in, dma_ack_out, dma_rdata_out
//             vram_cs/wr_en/addr/data_out, vram_data_in (read data valid in
//             the cycle after the cs cycle)
//             busy_out (state != IDLE), grant_id_out (0=CPU, 1=DMA)
//  Revision : 1.0  initial release
// ============================================================================
module fc8_vram_arbiter #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_in,
  input  logic              cpu_we_in,
  input  logic [AWIDTH-1:0] cpu_addr_in,
  input  logic [DWIDTH-1:0] cpu_wdata_in,
  output logic              cpu_ack_out,
  output logic [DWIDTH-1:0] cpu_rdata_out,
  input  logic              dma_req_in,
  input  logic              dma_we_in,
  input  logic [AWIDTH-1:0] dma_addr_in,
  input  logic [DWIDTH-1:0] dma_wdata_in,
  output logic              dma_ack_out,
  output logic [DWIDTH-1:0] dma_rdata_out,
  output logic              vram_cs_out,
  output logic              vram_wr_en_out,
  output logic [AWIDTH-1:0] vram_addr_out,
  output logic [DWIDTH-1:0] vram_data_out,
  input  logic [DWIDTH-1:0] vram_data_in,
  output logic              busy_out,
  output logic              grant_id_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                grant_id_q, grant_id_d;
  logic                we_q, we_d;        // access direction, kept past CMD
  logic                cs_q, cs_d;
  logic                wr_en_q, wr_en_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   data_q, data_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                dma_ack_q, dma_ack_d;
  logic [DWIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DWIDTH-1:0]   dma_rdata_q, dma_rdata_d;
  logic                busy_q, busy_d;

  logic                any_req;
  logic                win;               // 1 = DMA wins this arbitration

  assign any_req = cpu_req_in | dma_req_in;

`ifdef FC8_VRAM_ARB_RR_EN
  // Last-winner pointer; resets to DMA so the first tie goes to the CPU.
  logic last_q, last_d;

  always_comb begin
    win    = dma_req_in;
    if (cpu_req_in && dma_req_in) begin
      win = ~last_q;
    end
    last_d = last_q;
    if (state_q == ST_IDLE && any_req) begin
      last_d = win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign win = dma_req_in & ~cpu_req_in;
`endif

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    we_d        = we_q;
    cs_d        = cs_q;
    wr_en_d     = wr_en_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cpu_ack_d   = cpu_ack_q;
    dma_ack_d   = dma_ack_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d    = ST_CMD;
          grant_id_d = win;
          we_d       = win ? dma_we_in    : cpu_we_in;
          addr_d     = win ? dma_addr_in  : cpu_addr_in;
          data_d     = win ? dma_wdata_in : cpu_wdata_in;
          cs_d       = 1'b1;
          wr_en_d    = win ? dma_we_in    : cpu_we_in;
        end
      end
      ST_CMD: begin
        // addr/data keep their values to avoid needless toggling.
        state_d = ST_RESP;
        cs_d    = 1'b0;
        wr_en_d = 1'b0;
      end
      ST_RESP: begin
        state_d = ST_DONE;
        if (grant_id_q) begin
          dma_ack_d = 1'b1;
          if (!we_q) dma_rdata_d = vram_data_in;
        end else begin
          cpu_ack_d = 1'b1;
          if (!we_q) cpu_rdata_d = vram_data_in;
        end
      end
      default: begin // ST_DONE
        state_d   = ST_IDLE;
        cpu_ack_d = 1'b0;
        dma_ack_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_id_q  <= 1'b0;
      we_q        <= 1'b0;
      cs_q        <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      we_q        <= we_d;
      cs_q        <= cs_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_ack_out    = cpu_ack_q;
  assign cpu_rdata_out  = cpu_rdata_q;
  assign dma_ack_out    = dma_ack_q;
  assign dma_rdata_out  = dma_rdata_q;
  assign vram_cs_out    = cs_q;
  assign vram_wr_en_out = wr_en_q;
  assign vram_addr_out  = addr_q;
  assign vram_data_out  = data_q;
  assign busy_out       = busy_q;
  assign grant_id_out   = grant_id_q;

endmodule
`default_nettype wire
